// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO read-side burst master.
// The state encodings are common to every FIFO-side reader.
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_BURST = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 8;

endpackage

// File: rtl/fifo_burst_reader.sv
// Drains a programmed number of entries from a look-ahead FIFO and presents them as a
// valid/ready stream with an end-of-burst flag, one word per cycle under no backpressure.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    output logic                  o_fifo_drop,
    input  logic                  i_start,
    input  logic [LEN_WIDTH-1:0]  i_burst_len,
    input  logic                  i_abort,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [LEN_WIDTH-1:0]  o_words_left,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output logic                  o_m_valid,
    output logic                  o_m_last,
    input  logic                  i_m_ready
);

    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    rd_state_e             r_state;
    logic [LEN_WIDTH-1:0]  r_words_left;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_valid;
    logic                  r_m_last;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_xfer;
    logic                  w_words_nz;
    logic                  w_final_word;
    logic                  w_drop;

    assign w_xfer       = r_m_valid & i_m_ready;
    assign w_words_nz   = (r_words_left != LEN_ZERO);
    assign w_final_word = (r_words_left == LEN_ONE);

    // FIFO pop request; reset and abort suppress it so a killed burst never consumes an extra entry.
    always_comb begin
        w_drop = 1'b0;
        if (i_rst && !i_abort && (r_state == RD_BURST)) begin
            w_drop = ~i_fifo_empty & w_words_nz & (~r_m_valid | i_m_ready);
        end else begin
            w_drop = 1'b0;
        end
    end

    // Burst FSM, word counter and single-entry output register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= RD_IDLE;
            r_words_left <= LEN_ZERO;
            r_m_data     <= DATA_ZERO;
            r_m_valid    <= 1'b0;
            r_m_last     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (i_abort) begin
            // A word still held in the output register is dropped; it already left the FIFO.
            r_state      <= RD_IDLE;
            r_words_left <= LEN_ZERO;
            r_m_valid    <= 1'b0;
            r_m_last     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                RD_IDLE: begin
                    if (i_start && (i_burst_len != LEN_ZERO)) begin
                        r_state      <= RD_BURST;
                        r_words_left <= i_burst_len;
                        r_busy       <= 1'b1;
                    end
                end
                RD_BURST: begin
                    if (w_drop) begin
                        r_m_data     <= i_fifo_data;
                        r_m_valid    <= 1'b1;
                        r_m_last     <= w_final_word;
                        r_words_left <= r_words_left - LEN_ONE;
                        if (w_final_word) begin
                            r_state <= RD_DRAIN;
                        end
                    end else if (w_xfer) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                    end
                end
                RD_DRAIN: begin
                    // Only the final word can be pending here.
                    if (w_xfer) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        r_state   <= RD_IDLE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= RD_IDLE;
                    r_words_left <= LEN_ZERO;
                    r_m_valid    <= 1'b0;
                    r_m_last     <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign o_fifo_drop  = w_drop;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_words_left = r_words_left;
    assign o_m_data     = r_m_data;
    assign o_m_valid    = r_m_valid;
    assign o_m_last     = r_m_last;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a small look-ahead FIFO (depth 8) as the source.
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_rst_n;
    logic        start;
    logic [7:0]  burst_len;
    logic        abort;
    logic        m_ready;
    logic        push;
    logic [31:0] push_data;

    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_drop;
    logic        busy;
    logic        done;
    logic [7:0]  words_left;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;

    logic [31:0] f_mem [0:7];
    logic [2:0]  f_rd;
    logic [2:0]  f_wr;
    logic [3:0]  f_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_fifo_empty (fifo_empty),
        .i_fifo_data  (fifo_data),
        .o_fifo_drop  (fifo_drop),
        .i_start      (start),
        .i_burst_len  (burst_len),
        .i_abort      (abort),
        .o_busy       (busy),
        .o_done       (done),
        .o_words_left (words_left),
        .o_m_data     (m_data),
        .o_m_valid    (m_valid),
        .o_m_last     (m_last),
        .i_m_ready    (m_ready)
    );

    // Look-ahead source FIFO: head entry always visible, one pop per cycle with drop high.
    assign fifo_empty = (f_cnt == 4'd0);
    assign fifo_data  = f_mem[f_rd];

    always @(posedge clk) begin
        if (!fifo_rst_n) begin
            f_rd  <= 3'd0;
            f_wr  <= 3'd0;
            f_cnt <= 4'd0;
        end else begin
            if (fifo_drop && (f_cnt != 4'd0)) f_rd <= f_rd + 3'd1;
            if (push && (f_cnt != 4'd8)) begin
                f_mem[f_wr] <= push_data;
                f_wr        <= f_wr + 3'd1;
            end
            f_cnt <= f_cnt + {3'd0, (push && (f_cnt != 4'd8))} - {3'd0, (fifo_drop && (f_cnt != 4'd0))};
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            push      = 1'b1;
            push_data = base + 32'(i);
            cyc();
        end
        push = 1'b0;
    endtask

    task automatic flush();
        fifo_rst_n = 1'b0;
        cyc();
        fifo_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; fifo_rst_n = 1'b0; start = 1'b0; burst_len = 8'd0; abort = 1'b0;
        m_ready = 1'b0; push = 1'b0; push_data = 32'd0;
        repeat (3) cyc();
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
        n_total++; if (m_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", m_valid); else n_pass++;
        n_total++; if (m_last !== 1'b0) $display("FAIL reset_last got=%b exp=0", m_last); else n_pass++;
        n_total++; if (words_left !== 8'd0) $display("FAIL reset_words got=%0d exp=0", words_left); else n_pass++;
        n_total++; if (m_data !== 32'd0) $display("FAIL reset_data got=%h exp=0", m_data); else n_pass++;
        n_total++; if (fifo_drop !== 1'b0) $display("FAIL reset_drop got=%b exp=0", fifo_drop); else n_pass++;
        rst = 1'b1; fifo_rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        logic e_valid, e_last, e_done, e_busy, e_drop;
        logic [31:0] e_data;
        fill(4, 32'h0000_00A0);
        m_ready = 1'b1; burst_len = 8'd4; start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            start = 1'b0; burst_len = 8'd0;
            #1;
            e_valid = (c >= 2) && (c <= 5);
            e_last  = (c == 5);
            e_done  = (c == 6);
            e_busy  = (c <= 5);
            e_drop  = (c <= 4);
            e_data  = 32'h0000_00A0 + 32'(c - 2);
            n_total++; if (m_valid !== e_valid) $display("FAIL basic_valid c=%0d got=%b exp=%b", c, m_valid, e_valid); else n_pass++;
            n_total++; if (m_last !== e_last) $display("FAIL basic_last c=%0d got=%b exp=%b", c, m_last, e_last); else n_pass++;
            n_total++; if (done !== e_done) $display("FAIL basic_done c=%0d got=%b exp=%b", c, done, e_done); else n_pass++;
            n_total++; if (busy !== e_busy) $display("FAIL basic_busy c=%0d got=%b exp=%b", c, busy, e_busy); else n_pass++;
            n_total++; if (fifo_drop !== e_drop) $display("FAIL basic_drop c=%0d got=%b exp=%b", c, fifo_drop, e_drop); else n_pass++;
            if (e_valid) begin
                n_total++; if (m_data !== e_data) $display("FAIL basic_data c=%0d got=%h exp=%h", c, m_data, e_data); else n_pass++;
            end
        end
        n_total++; if (f_cnt !== 4'd0) $display("FAIL basic_fifo_cnt got=%0d exp=0", f_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic e_valid, e_last, e_done, e_drop;
        logic [31:0] e_data;
        fill(4, 32'h0000_00A0);
        m_ready = 1'b1; burst_len = 8'd4; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            start   = 1'b0;
            m_ready = !((c >= 3) && (c <= 5));
            #1;
            e_valid = (c >= 2) && (c <= 8);
            e_last  = (c == 8);
            e_done  = (c == 9);
            e_drop  = (c == 1) || (c == 2) || (c == 6) || (c == 7);
            e_data  = (c == 2) ? 32'h0000_00A0 : (c <= 6) ? 32'h0000_00A1 : (c == 7) ? 32'h0000_00A2 : 32'h0000_00A3;
            n_total++; if (m_valid !== e_valid) $display("FAIL bp_valid c=%0d got=%b exp=%b", c, m_valid, e_valid); else n_pass++;
            n_total++; if (m_last !== e_last) $display("FAIL bp_last c=%0d got=%b exp=%b", c, m_last, e_last); else n_pass++;
            n_total++; if (done !== e_done) $display("FAIL bp_done c=%0d got=%b exp=%b", c, done, e_done); else n_pass++;
            n_total++; if (fifo_drop !== e_drop) $display("FAIL bp_drop c=%0d got=%b exp=%b", c, fifo_drop, e_drop); else n_pass++;
            if (e_valid) begin
                n_total++; if (m_data !== e_data) $display("FAIL bp_data c=%0d got=%h exp=%h", c, m_data, e_data); else n_pass++;
            end
            if ((c >= 3) && (c <= 5)) begin
                n_total++; if (f_cnt !== 4'd2) $display("FAIL bp_fifo_cnt c=%0d got=%0d exp=2", c, f_cnt); else n_pass++;
            end
        end
        m_ready = 1'b1;
    endtask

    task automatic test_underrun();
        logic e_valid, e_drop;
        logic [31:0] e_data;
        flush();
        m_ready = 1'b1; burst_len = 8'd3; start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            cyc();
            start     = 1'b0;
            push      = (c == 2) || (c == 7) || (c == 12);
            push_data = (c == 2) ? 32'h11 : (c == 7) ? 32'h22 : 32'h33;
            #1;
            e_valid = (c == 4) || (c == 9) || (c == 14);
            e_drop  = (c == 3) || (c == 8) || (c == 13);
            e_data  = (c == 4) ? 32'h11 : (c == 9) ? 32'h22 : 32'h33;
            n_total++; if (m_valid !== e_valid) $display("FAIL ur_valid c=%0d got=%b exp=%b", c, m_valid, e_valid); else n_pass++;
            n_total++; if (fifo_drop !== e_drop) $display("FAIL ur_drop c=%0d got=%b exp=%b", c, fifo_drop, e_drop); else n_pass++;
            n_total++; if (m_last !== (c == 14)) $display("FAIL ur_last c=%0d got=%b exp=%b", c, m_last, (c == 14)); else n_pass++;
            n_total++; if (done !== (c == 15)) $display("FAIL ur_done c=%0d got=%b exp=%b", c, done, (c == 15)); else n_pass++;
            n_total++; if (busy !== (c <= 14)) $display("FAIL ur_busy c=%0d got=%b exp=%b", c, busy, (c <= 14)); else n_pass++;
            if (e_valid) begin
                n_total++; if (m_data !== e_data) $display("FAIL ur_data c=%0d got=%h exp=%h", c, m_data, e_data); else n_pass++;
            end
        end
        push = 1'b0;
    endtask

    task automatic test_start_ignore();
        int nwords = 0;
        int ndone  = 0;
        flush();
        burst_len = 8'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            n_total++; if (busy !== 1'b0) $display("FAIL len0_busy c=%0d got=%b exp=0", c, busy); else n_pass++;
        end
        fill(7, 32'h0000_0050);
        m_ready = 1'b1; burst_len = 8'd5; start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            start     = (c == 2);
            burst_len = (c == 2) ? 8'd2 : 8'd0;
            #1;
            if (m_valid && m_ready) begin
                n_total++; if (m_data !== 32'h50 + 32'(nwords)) $display("FAIL restart_data n=%0d got=%h exp=%h", nwords, m_data, 32'h50 + 32'(nwords)); else n_pass++;
                nwords++;
            end
            if (done) begin
                ndone++;
                n_total++; if (busy !== 1'b0) $display("FAIL restart_done_busy c=%0d got=%b exp=0", c, busy); else n_pass++;
            end
        end
        start = 1'b0;
        n_total++; if (nwords != 5) $display("FAIL restart_words got=%0d exp=5", nwords); else n_pass++;
        n_total++; if (ndone != 1) $display("FAIL restart_done_cnt got=%0d exp=1", ndone); else n_pass++;
        n_total++; if (f_cnt !== 4'd2) $display("FAIL restart_fifo_cnt got=%0d exp=2", f_cnt); else n_pass++;
    endtask

    task automatic test_abort(input bit use_rst);
        flush();
        fill(6, 32'h0000_0060);
        m_ready = 1'b1; burst_len = 8'd6; start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            start = 1'b0;
            abort = (c == 4) && !use_rst;
            rst   = !((c == 4) && use_rst);
            #1;
            if (c == 2 || c == 3) begin
                n_total++; if (m_data !== 32'h5E + 32'(c)) $display("FAIL abort_data r=%0d c=%0d got=%h exp=%h", use_rst, c, m_data, 32'h5E + 32'(c)); else n_pass++;
            end
            if (c == 4) begin
                n_total++; if (m_valid !== 1'b1 || m_data !== 32'h62) $display("FAIL abort_held r=%0d got=%b/%h exp=1/62", use_rst, m_valid, m_data); else n_pass++;
                n_total++; if (fifo_drop !== 1'b0) $display("FAIL abort_drop r=%0d got=%b exp=0", use_rst, fifo_drop); else n_pass++;
                n_total++; if (words_left !== 8'd3) $display("FAIL abort_words_pre r=%0d got=%0d exp=3", use_rst, words_left); else n_pass++;
            end
            if (c >= 5) begin
                n_total++; if (busy !== 1'b0) $display("FAIL abort_busy r=%0d c=%0d got=%b exp=0", use_rst, c, busy); else n_pass++;
                n_total++; if (m_valid !== 1'b0 || m_last !== 1'b0) $display("FAIL abort_valid r=%0d c=%0d got=%b%b exp=00", use_rst, c, m_valid, m_last); else n_pass++;
                n_total++; if (words_left !== 8'd0) $display("FAIL abort_words r=%0d c=%0d got=%0d exp=0", use_rst, c, words_left); else n_pass++;
                n_total++; if (done !== 1'b0) $display("FAIL abort_done r=%0d c=%0d got=%b exp=0", use_rst, c, done); else n_pass++;
            end
        end
        n_total++; if (f_cnt !== 4'd3) $display("FAIL abort_fifo_cnt r=%0d got=%0d exp=3", use_rst, f_cnt); else n_pass++;
    endtask

    task automatic test_len1();
        flush();
        fill(1, 32'h0000_0077);
        m_ready = 1'b1; burst_len = 8'd1; start = 1'b1;
        cyc();
        start = 1'b0;
        #1;
        n_total++; if (fifo_drop !== 1'b1) $display("FAIL len1_drop got=%b exp=1", fifo_drop); else n_pass++;
        cyc();
        n_total++; if ({m_valid, m_last} !== 2'b11) $display("FAIL len1_valid_last got=%b%b exp=11", m_valid, m_last); else n_pass++;
        n_total++; if (m_data !== 32'h77) $display("FAIL len1_data got=%h exp=77", m_data); else n_pass++;
        cyc();
        n_total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL len1_done got=%b/%b exp=1/0", done, busy); else n_pass++;
    endtask

    task automatic test_len255();
        int next  = 4;
        int ndone = 0;
        flush();
        fill(4, 32'h0000_1000);
        m_ready = 1'b1; burst_len = 8'd255; start = 1'b1;
        for (int c = 1; c <= 260; c++) begin
            cyc();
            start     = 1'b0;
            push      = (next < 255);
            push_data = 32'h1000 + 32'(next);
            if (next < 255) next++;
            #1;
            if (c >= 2 && c <= 256) begin
                n_total++; if (m_valid !== 1'b1) $display("FAIL l255_gap c=%0d got=%b exp=1", c, m_valid); else n_pass++;
                n_total++; if (m_data !== 32'h1000 + 32'(c - 2)) $display("FAIL l255_data c=%0d got=%h exp=%h", c, m_data, 32'h1000 + 32'(c - 2)); else n_pass++;
                n_total++; if (m_last !== (c == 256)) $display("FAIL l255_last c=%0d got=%b exp=%b", c, m_last, (c == 256)); else n_pass++;
            end
            if (done) begin
                ndone++;
                n_total++; if (c != 257) $display("FAIL l255_done_cycle got=%0d exp=257", c); else n_pass++;
            end
        end
        push = 1'b0;
        n_total++; if (ndone != 1) $display("FAIL l255_done_cnt got=%0d exp=1", ndone); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL l255_busy got=%b exp=0", busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_underrun();
        test_start_ignore();
        test_abort(1'b0);
        test_abort(1'b1);
        test_len1();
        test_len255();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
